// File: rtl/dp_sequencer.sv
// ---------------------------------------------------------------------------
// dp_sequencer
//
// Control FSM that steps the datapath through one instruction per start
// pulse. It latches a 16-bit instruction word in WAIT, decodes it, and
// then walks through register-read, execute and writeback states. Each
// state asserts the matching datapath strobes. w reports readiness for the
// next instruction.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (aborts any instruction)
//   s            start; only looked at while in WAIT
//   in[15:0]     instruction word, captured on the accepting edge
//   w            high only in WAIT
//   readnum      register read index (Rn in GETA, Rm in GETB)
//   writenum     register write index (Rn in WIMM, Rd in WRD)
//   loada/loadb  load the A / B operand registers
//   asel         1 forces the A operand to zero (used by MOV Rd,Rm)
//   bsel         B operand select, always 0
//   shift        shifter control (sh field) during ALU
//   ALUop        ALU operation (op field, 00 for MOV Rd,Rm) during ALU
//   loadc/loads  load the result register / status register
//   vsel         1 writes datapath_in back instead of the C register
//   write        register file write enable
//   datapath_in  sign-extended imm8 of the latched instruction
//   illegal      illegal-instruction flag
//
// Build option:
//   DP_SEQ_ILLEGAL_DET_EN - when defined, illegal pulses high during the
//   DECODE cycle of an unsupported instruction. Otherwise it is tied low.
// ---------------------------------------------------------------------------
module dp_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic [15:0] in,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic        vsel,
   output logic        write,
   output logic [15:0] datapath_in,
   output logic        illegal
);

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_WIMM   = 3'd2,
      S_GETA   = 3'd3,
      S_GETB   = 3'd4,
      S_ALU    = 3'd5,
      S_WRD    = 3'd6
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] ir;

   // Instruction field views of the latched word
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn;
   logic [2:0] rd;
   logic [1:0] sh;
   logic [2:0] rm;
   logic [7:0] imm8;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign imm8   = ir[7:0];

   // Instruction classes. Every op value under opcode 101 is a legal ALU
   // instruction. Under 110 only op 10 (immediate) and op 00 (register)
   // are defined.
   logic is_mov_imm;
   logic is_mov_reg;
   logic is_alu;
   logic is_cmp;
   logic is_mvn;
   logic is_legal;

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

   assign datapath_in = {{8{imm8[7]}}, imm8};

   // State and instruction register. The instruction is only captured on
   // the edge that accepts a start in WAIT. This makes later changes on
   // `in` invisible until the next accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= 16'h0000;
      end else begin
         state <= next_state;
         if (state == S_WAIT && s)
            ir <= in;
      end
   end

   // Next-state and Moore output decode. Everything defaults to idle so
   // each state only lists the controls it actually drives.
   always_comb begin
      next_state = state;
      w          = 1'b0;
      readnum    = 3'd0;
      writenum   = 3'd0;
      loada      = 1'b0;
      loadb      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      shift      = 2'b00;
      ALUop      = 2'b00;
      loadc      = 1'b0;
      loads      = 1'b0;
      vsel       = 1'b0;
      write      = 1'b0;

      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s)
               next_state = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)
               next_state = S_WIMM;
            else if (is_mov_reg || is_mvn)
               next_state = S_GETB;
            else if (is_alu)
               next_state = S_GETA;
            else
               next_state = S_WAIT;
         end
         S_WIMM: begin
            writenum   = rn;
            vsel       = 1'b1;
            write      = 1'b1;
            next_state = S_WAIT;
         end
         S_GETA: begin
            readnum    = rn;
            loada      = 1'b1;
            next_state = S_GETB;
         end
         S_GETB: begin
            readnum    = rm;
            loadb      = 1'b1;
            next_state = S_ALU;
         end
         S_ALU: begin
            shift = sh;
            asel  = is_mov_reg;
            ALUop = is_mov_reg ? 2'b00 : op;
            if (is_cmp) begin
               loads      = 1'b1;
               next_state = S_WAIT;
            end else begin
               loadc      = 1'b1;
               next_state = S_WRD;
            end
         end
         S_WRD: begin
            writenum   = rd;
            write      = 1'b1;
            next_state = S_WAIT;
         end
         default: begin
            next_state = S_WAIT;
         end
      endcase
   end

`ifdef DP_SEQ_ILLEGAL_DET_EN
   // Flag is decoded from the state, so it lasts exactly the one DECODE cycle
   assign illegal = (state == S_DECODE) && !is_legal;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dp_sequencer
//
// Scoreboard bench for dp_sequencer. For each accepted instruction, the
// driver expands it into the list of per-cycle control vectors the
// sequencer should show. It expands them from the instruction's class and
// fields, and queues that list. A monitor on the falling edge pops one
// vector per cycle and compares it against the DUT. With nothing queued,
// it expects the idle WAIT vector.
// ---------------------------------------------------------------------------
module tb_dp_sequencer;

   logic        clk;
   logic        reset;
   logic        s;
   logic [15:0] in;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic        loadc;
   logic        loads;
   logic        vsel;
   logic        write;
   logic [15:0] datapath_in;
   logic        illegal;

   dp_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .s           (s),
      .in          (in),
      .w           (w),
      .readnum     (readnum),
      .writenum    (writenum),
      .loada       (loada),
      .loadb       (loadb),
      .asel        (asel),
      .bsel        (bsel),
      .shift       (shift),
      .ALUop       (ALUop),
      .loadc       (loadc),
      .loads       (loads),
      .vsel        (vsel),
      .write       (write),
      .datapath_in (datapath_in),
      .illegal     (illegal)
   );

   // One cycle's worth of sequencer outputs
   typedef struct packed {
      logic        w;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        loada;
      logic        loadb;
      logic        asel;
      logic        bsel;
      logic [1:0]  shift;
      logic [1:0]  aluop;
      logic        loadc;
      logic        loads;
      logic        vsel;
      logic        write;
      logic [15:0] dp;
      logic        illegal;
   } ctl_t;

   ctl_t        exp_q[$];
   string       name_q[$];
   logic [15:0] last_dp;
   bit          mon_en;
   int          total;
   int          bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed vector with its expected value and keep score
   task automatic checkOutput(input string name, input ctl_t act, input ctl_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h (w rn wn la lb as bs sh op lc ls vs wr dp ill)",
                  name, act, exp);
      end
   endtask

   // Expand an instruction into its expected cycle-by-cycle control
   // vectors, starting with the cycle after the accept edge and ending
   // with the first ready cycle
   function automatic int model_push(input logic [15:0] ins);
      logic [2:0] opc;
      logic [1:0] opf;
      ctl_t       base;
      ctl_t       c;
      bit         mov_imm;
      bit         mov_reg;
      bit         alu;
      int         n;
      opc     = ins[15:13];
      opf     = ins[12:11];
      mov_imm = (opc == 3'b110) && (opf == 2'b10);
      mov_reg = (opc == 3'b110) && (opf == 2'b00);
      alu     = (opc == 3'b101);
      base    = '0;
      base.dp = {{8{ins[7]}}, ins[7:0]};
      last_dp = base.dp;
      n       = 0;

      // Decode cycle
      c = base;
`ifdef DP_SEQ_ILLEGAL_DET_EN
      c.illegal = !(mov_imm || mov_reg || alu);
`endif
      exp_q.push_back(c); name_q.push_back($sformatf("decode_%h", ins)); n++;

      if (mov_imm) begin
         c = base; c.writenum = ins[10:8]; c.vsel = 1'b1; c.write = 1'b1;
         exp_q.push_back(c); name_q.push_back($sformatf("wimm_%h", ins)); n++;
      end else if (mov_reg || alu) begin
         // Operand reads: Rn only for two-operand ALU ops, Rm always
         if (alu && opf != 2'b11) begin
            c = base; c.readnum = ins[10:8]; c.loada = 1'b1;
            exp_q.push_back(c); name_q.push_back($sformatf("geta_%h", ins)); n++;
         end
         c = base; c.readnum = ins[2:0]; c.loadb = 1'b1;
         exp_q.push_back(c); name_q.push_back($sformatf("getb_%h", ins)); n++;
         c = base; c.shift = ins[4:3];
         c.asel  = mov_reg;
         c.aluop = mov_reg ? 2'b00 : opf;
         if (alu && opf == 2'b01) c.loads = 1'b1;
         else                     c.loadc = 1'b1;
         exp_q.push_back(c); name_q.push_back($sformatf("alu_%h", ins)); n++;
         if (!(alu && opf == 2'b01)) begin
            c = base; c.writenum = ins[7:5]; c.write = 1'b1;
            exp_q.push_back(c); name_q.push_back($sformatf("wrd_%h", ins)); n++;
         end
      end

      // First ready cycle
      c = base; c.w = 1'b1;
      exp_q.push_back(c); name_q.push_back($sformatf("ready_%h", ins)); n++;
      return n;
   endfunction

   // Monitor: one comparison per cycle on the falling edge
   always @(negedge clk) begin
      ctl_t  act;
      ctl_t  exp;
      string nm;
      if (mon_en) begin
         act = {w, readnum, writenum, loada, loadb, asel, bsel, shift, ALUop,
                loadc, loads, vsel, write, datapath_in, illegal};
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
         end else begin
            exp = '0; exp.w = 1'b1; exp.dp = last_dp;
            nm  = "idle";
         end
         checkOutput(nm, act, exp);
      end
   end

   // Issue one instruction. Entered and left 1 time unit after a rising
   // edge in a WAIT cycle. While the instruction runs, s and in are
   // scrambled, and the DUT must ignore both.
   task automatic applyStimulus(input logic [15:0] ins, input bit back_to_back);
      int lat;
      s  = 1'b1;
      in = ins;
      @(posedge clk); #1;
      lat = model_push(ins);
      for (int k = 1; k < lat; k++) begin
         s  = 1'($urandom);
         in = 16'($urandom);
         @(posedge clk); #1;
      end
      s = 1'b0;
      if (!back_to_back) begin
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            @(posedge clk); #1;
         end
      end
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      int          kind;
      r    = 16'($urandom);
      kind = int'($urandom_range(0, 6));
      case (kind)
         0:       r[15:11] = 5'b110_10;
         1:       r[15:11] = 5'b110_00;
         2, 3, 4, 5: begin
            r[15:13] = 3'b101;
            r[12:11] = 2'(kind - 2);
         end
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      total   = 0;
      bad     = 0;
      mon_en  = 1'b0;
      last_dp = 16'h0000;
      reset   = 1'b1;
      s       = 1'b0;
      in      = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed instructions");
      applyStimulus(16'hD007, 1'b0);
      applyStimulus(16'hD1FE, 1'b1);
      applyStimulus(16'hA148, 1'b0);
      applyStimulus(16'hA801, 1'b1);
      applyStimulus(16'hE000, 1'b0);
      applyStimulus(16'hC00B, 1'b0);
      applyStimulus(16'hBE6C, 1'b0);

      $display("[TB] random instructions");
      for (int i = 0; i < 60; i++)
         applyStimulus(rand_instr(), 1'($urandom));

      $display("[TB] reset during GETB");
      s  = 1'b1;
      in = 16'hA148;
      @(posedge clk); #1;
      void'(model_push(16'hA148));
      while (exp_q.size() > 3) begin
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end
      s = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset   = 1'b1;
      last_dp = 16'h0000;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end

      applyStimulus(16'hD07F, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got=%0d leftover expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
